mac_stop: RTL and testbench
===========================

// Module: mac_stop
// PURPOSE
//  Accumulate (MAC) stage of the matrix-multiply pipeline, computing C[MxN] = A[MxK] * B[KxN].
//  Sits after the multiply stage and takes one A*B partial product per valid cycle.
//  Sums K consecutive products into one C element, then emits the element with its
//  C row/col address and a one-cycle write enable for the C memory.
//  Raises mac_done once the last C element (M-1, N-1) has been written.
// PARAMETERS
//  M                         3                    rows of A / C
//  K                         5                    cols of A = rows of B (terms per dot product)
//  N                         5                    cols of B / C
//  DATA_WIDTH_INIT_MATRIX    32                   A/B element width (DW)
//  DATA_WIDTH_RESULT_MATRIX  2*DW+$clog2(K)       C element width (DWR); must be >= 2*DW+$clog2(K)
// PORTS
//  clk                            in   1              rising-edge clock
//  resetn                         in   1              asynchronous reset, active-high (asserted when 1)
//  product_reg                    in   2*DW           unsigned partial product A[i][k]*B[k][j]
//  matrix_a_col_addr_counter_reg  in   $clog2(K)      k index of the product (A col)
//  matrix_b_row_addr_counter_reg  in   $clog2(K)      k index of the product (B row); equals A col
//  matrix_a_row_addr_counter_reg  in   $clog2(M)      i index (C row)
//  matrix_b_col_addr_counter_reg  in   $clog2(N)      j index (C col)
//  mult_done_reg                  in   1              product/index inputs valid this cycle
//  data_out_c                     out  DWR            completed C[i][j]
//  matrix_c_we                    out  1              C write strobe, 1 cycle per element
//  mac_done                       out  1              all M*N elements written (sticky)
//  row_addr_c                     out  $clog2(M)      C write row address
//  col_addr_c                     out  $clog2(N)      C write col address
// BEHAVIOUR
//  - Reset (resetn=1, async): accumulator, data_out_c, matrix_c_we, mac_done, row_addr_c,
//    col_addr_c all 0; FSM -> IDLE. Reset mid-operation discards the partial sum.
//  - FSM: IDLE -> ACCUM on first clk edge with mult_done_reg=1; ACCUM -> DONE on the edge that
//    writes element (M-1, N-1); DONE holds until reset, ignoring all inputs.
//  - Each rising edge with mult_done_reg=1 (IDLE/ACCUM): sum = acc + zero_ext(product_reg).
//    * k = matrix_a_col_addr_counter_reg != K-1: acc <= sum; matrix_c_we <= 0.
//    * k == K-1 (final term): data_out_c <= sum; row_addr_c <= a_row; col_addr_c <= b_col;
//      matrix_c_we <= 1; acc <= 0.
//  - mult_done_reg=0: acc holds; matrix_c_we <= 0. Gaps between valid terms are allowed.
//  - Latency: the result is registered; matrix_c_we, data_out_c and the address are visible
//    after the edge that samples the final term and stay for exactly one cycle.
//    data_out_c and the address hold their value until the next write.
//  - Back-to-back elements: the final term of one element and the first term of the next
//    arrive on consecutive cycles with no bubble.
//  - mac_done <= 1 on the same edge as the write of (M-1, N-1); stays 1 until reset.
//  - Arithmetic: unsigned, zero-extended to DWR. Width guarantees no overflow for K terms.
//  - Term order is k = 0..K-1 ascending. Only k == K-1 closes an element; the B row index
//    is not used for control.
// TESTING
//  - Reset: hold resetn=1 -> all outputs 0, no we; release, idle inputs -> outputs stay 0.
//  - 2x2x2, products 5,14 | 6,16 | 15,28 | 18,32 (k=0,1 per element)
//    -> writes (0,0)=19, (0,1)=22, (1,0)=43, (1,1)=50; mac_done after the 4th write.
//  - 3x5x5, (0,0) terms 20,20,18,20,30 -> 108; (0,1) terms 20,24,15,24,25 -> 108;
//    15 writes total, we pulses exactly 1 cycle each.
//  - Insert mult_done_reg=0 bubbles mid-element -> same sums, we delayed accordingly.
//  - Max product (2^(2*DW)-1) x K terms -> exact sum, no wrap, in DWR bits.
//  - Assert reset mid-element, then replay from k=0 -> correct sum; mac_done clear until
//    (M-1, N-1) is written again.

Source files
------------

// File: rtl/mac_stop.sv
// Accumulate stage of the matrix-multiply pipeline: sums K partial products per C element
// and issues a one-cycle registered write of the finished element with its row/col address.
module mac_stop #(
    parameter int M                        = 3,
    parameter int K                        = 5,
    parameter int N                        = 5,
    parameter int DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX = 2 * DATA_WIDTH_INIT_MATRIX + $clog2(K)
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic [2*DATA_WIDTH_INIT_MATRIX-1:0] product_reg,
    input  logic [$clog2(K)-1:0]                matrix_a_col_addr_counter_reg,
    input  logic [$clog2(K)-1:0]                matrix_b_row_addr_counter_reg,
    input  logic [$clog2(M)-1:0]                matrix_a_row_addr_counter_reg,
    input  logic [$clog2(N)-1:0]                matrix_b_col_addr_counter_reg,
    input  logic                                mult_done_reg,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_out_c,
    output logic                                matrix_c_we,
    output logic                                mac_done,
    output logic [$clog2(M)-1:0]                row_addr_c,
    output logic [$clog2(N)-1:0]                col_addr_c
);

    localparam int DWR = DATA_WIDTH_RESULT_MATRIX;
    localparam int KW  = $clog2(K);
    localparam int MW  = $clog2(M);
    localparam int NW  = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [DWR-1:0]   acc_r;
    logic [DWR-1:0]   acc_next_s;
    logic [DWR-1:0]   sum_s;
    logic [DWR-1:0]   data_next_s;
    logic [MW-1:0]    row_next_s;
    logic [NW-1:0]    col_next_s;
    logic             we_next_s;
    logic             done_next_s;
    logic             last_term_s;
    logic             last_elem_s;
    logic             unused_b_row_s;

    // The B row index mirrors the A column index and carries no control meaning here.
    assign unused_b_row_s = ^matrix_b_row_addr_counter_reg;

    assign last_term_s = (matrix_a_col_addr_counter_reg == KW'(K - 1));
    assign last_elem_s = (matrix_a_row_addr_counter_reg == MW'(M - 1)) &&
                         (matrix_b_col_addr_counter_reg == NW'(N - 1));

    // Next-state and next-output logic; every register holds unless a valid term arrives.
    always_comb begin
        state_next_s = state_r;
        acc_next_s   = acc_r;
        data_next_s  = data_out_c;
        row_next_s   = row_addr_c;
        col_next_s   = col_addr_c;
        we_next_s    = 1'b0;
        done_next_s  = mac_done;
        sum_s        = acc_r + DWR'(product_reg);
        case (state_r)
            IDLE, ACCUM: begin
                if (mult_done_reg) begin
                    if (last_term_s) begin
                        data_next_s = sum_s;
                        row_next_s  = matrix_a_row_addr_counter_reg;
                        col_next_s  = matrix_b_col_addr_counter_reg;
                        we_next_s   = 1'b1;
                        acc_next_s  = {DWR{1'b0}};
                        if (last_elem_s) begin
                            done_next_s  = 1'b1;
                            state_next_s = DONE;
                        end else begin
                            state_next_s = ACCUM;
                        end
                    end else begin
                        acc_next_s   = sum_s;
                        state_next_s = ACCUM;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            DONE: begin
                state_next_s = DONE;
            end
            default: begin
                state_next_s = IDLE;
                acc_next_s   = {DWR{1'b0}};
            end
        endcase
    end

    // State, accumulator and registered C-write outputs.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_r     <= IDLE;
            acc_r       <= {DWR{1'b0}};
            data_out_c  <= {DWR{1'b0}};
            matrix_c_we <= 1'b0;
            mac_done    <= 1'b0;
            row_addr_c  <= {MW{1'b0}};
            col_addr_c  <= {NW{1'b0}};
        end else begin
            state_r     <= state_next_s;
            acc_r       <= acc_next_s;
            data_out_c  <= data_next_s;
            matrix_c_we <= we_next_s;
            mac_done    <= done_next_s;
            row_addr_c  <= row_next_s;
            col_addr_c  <= col_next_s;
        end
    end

endmodule

// File: tb/tb_mac_stop.sv
// Directed bench for mac_stop: default 3x5x5 instance plus a 2x2x2 instance.
module tb_mac_stop;

    logic        clk;
    logic        resetn;

    logic [63:0] a_product;
    logic [2:0]  a_k;
    logic [2:0]  a_brow;
    logic [1:0]  a_i;
    logic [2:0]  a_j;
    logic        a_v;
    logic [66:0] a_data;
    logic        a_we;
    logic        a_done;
    logic [1:0]  a_row;
    logic [2:0]  a_col;

    logic [63:0] b_product;
    logic [0:0]  b_k;
    logic [0:0]  b_brow;
    logic [0:0]  b_i;
    logic [0:0]  b_j;
    logic        b_v;
    logic [64:0] b_data;
    logic        b_we;
    logic        b_done;
    logic [0:0]  b_row;
    logic [0:0]  b_col;

    int checks = 0;
    int errors = 0;

    int tbl00 [5] = '{20, 20, 18, 20, 30};
    int tbl01 [5] = '{20, 24, 15, 24, 25};

    mac_stop dut (
        .clk                           (clk),
        .resetn                        (resetn),
        .product_reg                   (a_product),
        .matrix_a_col_addr_counter_reg (a_k),
        .matrix_b_row_addr_counter_reg (a_brow),
        .matrix_a_row_addr_counter_reg (a_i),
        .matrix_b_col_addr_counter_reg (a_j),
        .mult_done_reg                 (a_v),
        .data_out_c                    (a_data),
        .matrix_c_we                   (a_we),
        .mac_done                      (a_done),
        .row_addr_c                    (a_row),
        .col_addr_c                    (a_col)
    );

    mac_stop #(.M(2), .K(2), .N(2)) dut2 (
        .clk                           (clk),
        .resetn                        (resetn),
        .product_reg                   (b_product),
        .matrix_a_col_addr_counter_reg (b_k),
        .matrix_b_row_addr_counter_reg (b_brow),
        .matrix_a_row_addr_counter_reg (b_i),
        .matrix_b_col_addr_counter_reg (b_j),
        .mult_done_reg                 (b_v),
        .data_out_c                    (b_data),
        .matrix_c_we                   (b_we),
        .mac_done                      (b_done),
        .row_addr_c                    (b_row),
        .col_addr_c                    (b_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_a(input logic [63:0] p, input int k, input int i, input int j);
        a_product = p;
        a_k       = 3'(k);
        a_brow    = 3'(k);
        a_i       = 2'(i);
        a_j       = 3'(j);
        a_v       = 1'b1;
        @(posedge clk);
        #1;
        a_v = 1'b0;
    endtask

    task automatic send_b(input logic [63:0] p, input int k, input int i, input int j);
        b_product = p;
        b_k       = 1'(k);
        b_brow    = 1'(k);
        b_i       = 1'(i);
        b_j       = 1'(j);
        b_v       = 1'b1;
        @(posedge clk);
        #1;
        b_v = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        idle(2);
        resetn = 1'b0;
        idle(1);
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        idle(3);
        checks++;
        if ({a_data, a_we, a_done, a_row, a_col} !== 73'd0) begin
            errors++;
            $display("FAIL reset_a: got data=%0d we=%b done=%b row=%0d col=%0d, want all 0",
                     a_data, a_we, a_done, a_row, a_col);
        end
        checks++;
        if ({b_data, b_we, b_done, b_row, b_col} !== 69'd0) begin
            errors++;
            $display("FAIL reset_b: got data=%0d we=%b done=%b, want all 0", b_data, b_we, b_done);
        end
        resetn = 1'b0;
        idle(3);
        checks++;
        if ({a_data, a_we, a_done, a_row, a_col} !== 73'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got data=%0d we=%b done=%b, want all 0",
                     a_data, a_we, a_done);
        end
    endtask

    task automatic test_2x2x2();
        int prods [8] = '{5, 14, 6, 16, 15, 28, 18, 32};
        int exps  [4] = '{19, 22, 43, 50};
        for (int e = 0; e < 4; e++) begin
            for (int k = 0; k < 2; k++) begin
                send_b(64'(prods[e*2+k]), k, e / 2, e % 2);
                if (k == 0) begin
                    checks++;
                    if (b_we !== 1'b0) begin
                        errors++;
                        $display("FAIL small_we_low e=%0d: got %b want 0", e, b_we);
                    end
                end else begin
                    checks++;
                    if (b_we !== 1'b1 || b_data !== 65'(exps[e]) || b_row !== 1'(e / 2) ||
                        b_col !== 1'(e % 2)) begin
                        errors++;
                        $display("FAIL small_write e=%0d: got we=%b data=%0d (%0d,%0d) want we=1 data=%0d (%0d,%0d)",
                                 e, b_we, b_data, b_row, b_col, exps[e], e / 2, e % 2);
                    end
                    checks++;
                    if (b_done !== (e == 3)) begin
                        errors++;
                        $display("FAIL small_done e=%0d: got %b want %b", e, b_done, (e == 3));
                    end
                end
            end
        end
        idle(1);
        checks++;
        if (b_we !== 1'b0 || b_done !== 1'b1 || b_data !== 65'd50) begin
            errors++;
            $display("FAIL small_after: got we=%b done=%b data=%0d want we=0 done=1 data=50",
                     b_we, b_done, b_data);
        end
    endtask

    task automatic test_full_back_to_back();
        logic [66:0] exp;
        logic [63:0] p;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 5; j++) begin
                exp = 67'd0;
                for (int k = 0; k < 5; k++) begin
                    if (i == 0 && j == 0) p = 64'(tbl00[k]);
                    else if (i == 0 && j == 1) p = 64'(tbl01[k]);
                    else p = 64'(i * 40 + j * 9 + k * 5 + 3);
                    exp = exp + 67'(p);
                    send_a(p, k, i, j);
                    if (k < 4) begin
                        checks++;
                        if (a_we !== 1'b0) begin
                            errors++;
                            $display("FAIL full_we_low (%0d,%0d) k=%0d: got %b want 0", i, j, k, a_we);
                        end
                    end else begin
                        checks++;
                        if (a_we !== 1'b1 || a_data !== exp || a_row !== 2'(i) || a_col !== 3'(j)) begin
                            errors++;
                            $display("FAIL full_write (%0d,%0d): got we=%b data=%0d at (%0d,%0d) want data=%0d",
                                     i, j, a_we, a_data, a_row, a_col, exp);
                        end
                        checks++;
                        if (a_done !== (i == 2 && j == 4)) begin
                            errors++;
                            $display("FAIL full_done (%0d,%0d): got %b want %b", i, j, a_done,
                                     (i == 2 && j == 4));
                        end
                    end
                end
            end
        end
        idle(1);
        checks++;
        if (a_we !== 1'b0 || a_done !== 1'b1) begin
            errors++;
            $display("FAIL full_after: got we=%b done=%b want we=0 done=1", a_we, a_done);
        end
        send_a(64'd99, 4, 0, 0);
        checks++;
        if (a_we !== 1'b0 || a_data !== exp || a_row !== 2'd2 || a_col !== 3'd4) begin
            errors++;
            $display("FAIL done_ignores: got we=%b data=%0d (%0d,%0d) want we=0 data=%0d (2,4)",
                     a_we, a_data, a_row, a_col, exp);
        end
    endtask

    task automatic test_bubbles();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send_a(64'(tbl00[k]), k, 0, 0);
            if (k < 4) begin
                idle(2);
                checks++;
                if (a_we !== 1'b0) begin
                    errors++;
                    $display("FAIL bubble_we k=%0d: got %b want 0", k, a_we);
                end
            end
        end
        checks++;
        if (a_we !== 1'b1 || a_data !== 67'd108) begin
            errors++;
            $display("FAIL bubble_sum: got we=%b data=%0d want we=1 data=108", a_we, a_data);
        end
        idle(1);
        checks++;
        if (a_we !== 1'b0 || a_data !== 67'd108 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL bubble_hold: got we=%b data=%0d done=%b want we=0 data=108 done=0",
                     a_we, a_data, a_done);
        end
    endtask

    task automatic test_max_product();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send_a({64{1'b1}}, k, 1, 3);
        end
        checks++;
        if (a_we !== 1'b1 || a_data !== 67'h4_FFFF_FFFF_FFFF_FFFB || a_row !== 2'd1 || a_col !== 3'd3) begin
            errors++;
            $display("FAIL max_sum: got we=%b data=%h (%0d,%0d) want data=4fffffffffffffffb (1,3)",
                     a_we, a_data, a_row, a_col);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send_a(64'd100, k, 0, 0);
        end
        resetn = 1'b1;
        #1;
        checks++;
        if ({a_data, a_we, a_done, a_row, a_col} !== 73'd0) begin
            errors++;
            $display("FAIL mid_reset_async: got data=%0d we=%b done=%b want all 0", a_data, a_we, a_done);
        end
        @(posedge clk);
        #1;
        resetn = 1'b0;
        idle(1);
        for (int k = 0; k < 5; k++) begin
            send_a(64'(tbl00[k]), k, 0, 0);
        end
        checks++;
        if (a_we !== 1'b1 || a_data !== 67'd108 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_replay: got we=%b data=%0d done=%b want we=1 data=108 done=0",
                     a_we, a_data, a_done);
        end
        for (int k = 0; k < 5; k++) begin
            send_a(64'(k + 1), k, 2, 4);
        end
        checks++;
        if (a_we !== 1'b1 || a_data !== 67'd15 || a_done !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_last: got we=%b data=%0d done=%b want we=1 data=15 done=1",
                     a_we, a_data, a_done);
        end
    endtask

    initial begin
        resetn    = 1'b1;
        a_product = 64'd0;
        a_k       = 3'd0;
        a_brow    = 3'd0;
        a_i       = 2'd0;
        a_j       = 3'd0;
        a_v       = 1'b0;
        b_product = 64'd0;
        b_k       = 1'd0;
        b_brow    = 1'd0;
        b_i       = 1'd0;
        b_j       = 1'd0;
        b_v       = 1'b0;
        test_reset();
        test_2x2x2();
        test_full_back_to_back();
        test_bubbles();
        test_max_product();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
